// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch. Owns the PC, selects next PC, registers the fetched word into IF/ID.
// Optional IF_PERF_CNT_EN adds saturating fetch_cnt/bubble_cnt outputs.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  redirect_sel,
  input  logic [31:0] id_pc4,
  input  logic [25:0] id_target26,
  input  logic [31:0] jr_target,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_ir,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_J   = 2'b01;
  localparam logic [1:0] SEL_JR  = 2'b10;
  localparam logic [1:0] SEL_BR  = 2'b11;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        take_bubble;
  logic        take_fetch;
  logic        unused_bits;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (redirect_sel)
      SEL_J:   next_pc = {id_pc4[31:28], id_target26, 2'b00};
      SEL_JR:  next_pc = {jr_target[31:2], 2'b00};
      SEL_BR:  next_pc = {branch_target[31:2], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  // A redirect always kills the word being fetched, same as an explicit flush.
  always_comb begin
    take_bubble = !stall && ((redirect_sel != SEL_SEQ) || flush);
    take_fetch  = !stall && (redirect_sel == SEL_SEQ) && !flush;
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (take_bubble) begin
      pc_d    = next_pc;
      ir_d    = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (take_fetch) begin
      pc_d    = pc_plus4;
      ir_d    = imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_ir    = ir_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

  // Only the top nibble of id_pc4 and the upper 30 bits of the register targets matter.
  assign unused_bits = ^{id_pc4[27:0], jr_target[1:0], branch_target[1:0]};

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (take_fetch && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (take_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: reference model pushes expected IF state per edge, popped and compared after the edge.
module tb_if_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush;
  logic [1:0]  redirect_sel;
  logic [31:0] id_pc4, jr_target, branch_target;
  logic [25:0] id_target26;
  logic [31:0] imem_addr, imem_rdata, pc, if_id_ir, if_id_pc4;
  logic        if_id_valid;
  logic [31:0] w_addr, w_rdata, w_pc, w_ir, w_pc4;
  logic        w_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt, w_fc, w_bc;
`endif

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h2008_0005;
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_rdata = imem_word(imem_addr);
  assign w_rdata    = imem_word(w_addr);

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect_sel(redirect_sel),
    .id_pc4(id_pc4), .id_target26(id_target26), .jr_target(jr_target), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc), .if_id_ir(if_id_ir),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect_sel(redirect_sel),
    .id_pc4(id_pc4), .id_target26(id_target26), .jr_target(jr_target), .branch_target(branch_target),
    .imem_addr(w_addr), .imem_rdata(w_rdata), .pc(w_pc), .if_id_ir(w_ir),
    .if_id_pc4(w_pc4), .if_id_valid(w_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(w_fc), .bubble_cnt(w_bc)
`endif
  );

  typedef struct {
    logic [31:0] pc, ir, pc4, fc, bc;
    logic        v;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_pc, m_ir, m_pc4, m_fc, m_bc;
  logic        m_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic fl, input logic [1:0] sel);
    exp_t e;
    reset = rst; stall = st; flush = fl; redirect_sel = sel;
    if (rst) begin
      m_pc = 32'd0; m_ir = 32'd0; m_pc4 = 32'd0; m_v = 1'b0; m_fc = 32'd0; m_bc = 32'd0;
    end else if (st) begin
      m_pc = m_pc;
    end else if (sel != 2'b00 || fl) begin
      case (sel)
        2'b01:   m_pc = {id_pc4[31:28], id_target26, 2'b00};
        2'b10:   m_pc = jr_target & 32'hFFFF_FFFC;
        2'b11:   m_pc = branch_target & 32'hFFFF_FFFC;
        default: m_pc = m_pc + 32'd4;
      endcase
      m_ir = 32'd0; m_pc4 = 32'd0; m_v = 1'b0;
      if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
    end else begin
      m_ir  = imem_word(m_pc);
      m_pc  = m_pc + 32'd4;
      m_pc4 = m_pc;
      m_v   = 1'b1;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
    end
    e.pc = m_pc; e.ir = m_ir; e.pc4 = m_pc4; e.v = m_v; e.fc = m_fc; e.bc = m_bc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("pc", pc, e.pc);
    check("imem_addr", imem_addr, e.pc);
    check("if_id_ir", if_id_ir, e.ir);
    check("if_id_pc4", if_id_pc4, e.pc4);
    check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.v});
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, e.fc);
    check("bubble_cnt", bubble_cnt, e.bc);
`endif
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_sel = 2'b00;
    id_pc4 = 32'd0; id_target26 = 26'd0; jr_target = 32'd0; branch_target = 32'd0;

    step(1, 0, 0, 2'b00);
    step(1, 0, 0, 2'b00);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);

    step(0, 0, 0, 2'b00);
    check("seq_pc", pc, 32'h4);
    check("seq_ir", if_id_ir, 32'h2008_0005);
    check("seq_pc4", if_id_pc4, 32'h4);
    check("seq_valid", {31'd0, if_id_valid}, 32'd1);
    check("wrap_pc", w_pc, 32'h0);
    check("wrap_pc4", w_pc4, 32'h0);
    check("wrap_ir", w_ir, 32'h0003_FFFC);

    for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00);
    check("pc_0x10", pc, 32'h10);

    id_pc4 = 32'h0000_000C; id_target26 = 26'h000_0040;
    step(0, 0, 0, 2'b01);
    check("j_pc", pc, 32'h100);
    check("j_ir", if_id_ir, 32'h0);
    check("j_valid", {31'd0, if_id_valid}, 32'd0);
    step(0, 0, 0, 2'b00);
    check("j_fetch_ir", if_id_ir, 32'hFEFF_0100);

    id_pc4 = 32'hA000_0000; id_target26 = 26'h3FF_FFFF;
    step(0, 0, 0, 2'b01);
    check("j_region_pc", pc, 32'hAFFF_FFFC);

    jr_target = 32'h0000_0203;
    step(0, 0, 0, 2'b10);
    check("jr_pc", pc, 32'h200);
    branch_target = 32'h0000_0044;
    step(0, 0, 0, 2'b11);
    check("br_pc", pc, 32'h44);
    check("br_valid", {31'd0, if_id_valid}, 32'd0);

    branch_target = 32'h0000_001F;
    step(0, 0, 0, 2'b11);
    step(0, 0, 0, 2'b00);
    branch_target = 32'h0000_0080;
    step(0, 1, 0, 2'b11);
    step(0, 1, 1, 2'b11);
    check("stall_pc", pc, 32'h20);
    check("stall_ir", if_id_ir, 32'hFFE3_001C);
    check("stall_pc4", if_id_pc4, 32'h20);
    step(0, 0, 0, 2'b11);
    check("unstall_pc", pc, 32'h80);

    branch_target = 32'h0000_0030;
    step(0, 0, 0, 2'b11);
    step(0, 0, 1, 2'b00);
    check("flush_pc", pc, 32'h34);
    check("flush_valid", {31'd0, if_id_valid}, 32'd0);
    step(0, 0, 0, 2'b00);
    check("post_flush_ir", if_id_ir, 32'hFFCB_0034);

    step(1, 1, 0, 2'b11);
    check("rst_mid_stall_pc", pc, 32'h0);

    id_pc4 = 32'h0000_0000; id_target26 = 26'h000_0010;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00);
    step(0, 1, 0, 2'b00);
    step(0, 0, 0, 2'b01);
    step(0, 0, 0, 2'b01);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", fetch_cnt, 32'd3);
    check("perf_bubble", bubble_cnt, 32'd2);
`endif
    step(1, 0, 0, 2'b01);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch_rst", fetch_cnt, 32'd0);
    check("perf_bubble_rst", bubble_cnt, 32'd0);
`endif
    check("final_rst_pc", pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; directly upstream of the decode stage, which it feeds through the IF/ID pipeline register.
- Owns the PC register and next-PC selection: sequential, j/jal, jr, or beq taken.
- Drives the instruction-memory address and captures the fetched word.
- Honours load-use stalls and control-hazard flushes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word injected into IF/ID on a bubble (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  load-use hazard; hold PC and IF/ID.
- flush  in  1  kill the instruction being fetched this cycle.
- redirect_sel  in  2  next-PC source from decode: 00 seq, 01 j/jal, 10 jr, 11 branch taken.
- id_pc4  in  32  PC+4 of the instruction currently in decode.
- id_target26  in  26  IR[25:0] of the instruction in decode.
- jr_target  in  32  forwarded rs value for jr.
- branch_target  in  32  id_pc4 + (sign-extended imm << 2), computed in decode.
- imem_addr  out  32  instruction-memory address; equals pc.
- imem_rdata  in  32  instruction word; combinational read of imem_addr.
- pc  out  32  current fetch PC.
- if_id_ir  out  32  registered instruction to decode.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: pc=RESET_PC, if_id_ir=NOP_WORD, if_id_pc4=0, if_id_valid=0.
- Timing: imem_addr=pc, combinational. Fetch latency is 1 cycle: the word at pc appears on if_id_ir on the edge that advances pc.
- Target formation:
  - j/jal target = {id_pc4[31:28], id_target26, 2'b00}.
  - jr target = {jr_target[31:2], 2'b00}; low bits are forced to 0.
  - branch target is used as given, with bits [1:0] forced to 0.
- Per-edge priority, highest first:
  1. reset: as above.
  2. stall=1: pc, if_id_ir, if_id_pc4, if_id_valid all hold. redirect_sel and flush are ignored; decode re-presents them next cycle.
  3. redirect_sel!=00: pc <= selected target; IF/ID loads the bubble (if_id_ir=NOP_WORD, if_id_valid=0, if_id_pc4=0). A redirect always implies a flush.
  4. flush=1 with redirect_sel=00: pc <= pc+4; IF/ID loads the bubble.
  5. Otherwise: pc <= pc+4; if_id_ir <= imem_rdata; if_id_pc4 <= pc+4; if_id_valid <= 1.
- PC+4 is a 32-bit add that wraps; 32'hFFFF_FFFC+4 gives 32'h0000_0000, no flag.
- Reset held over multiple cycles keeps all outputs at reset values. Reset asserted mid-stall or mid-redirect wins unconditionally.
- No combinational path from stall, flush or redirect inputs to any output except through registers.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds outputs fetch_cnt (32) and bubble_cnt (32):
  - fetch_cnt increments on each edge taking rule 5.
  - bubble_cnt increments on each edge taking rule 3 or 4.
  - Stall edges count in neither.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then sequential fetch: release reset, imem returns 32'h2008_0005 at pc 0 → after edge 1: pc=4, if_id_ir=32'h2008_0005, if_id_pc4=4, valid=1.
- Jump: at pc=0x10 drive redirect_sel=01, id_pc4=0x0C, id_target26=26'h000_0040 → pc=0x100, if_id_ir=0, valid=0; next edge fetches from 0x100.
- jr misaligned plus branch: redirect_sel=10, jr_target=0x0000_0203 → pc=0x200. Then redirect_sel=11, branch_target=0x44 → pc=0x44, bubble inserted.
- Stall beats redirect: pc=0x20, stall=1 and redirect_sel=11 for 2 cycles → pc stays 0x20, IF/ID unchanged. Drop stall with redirect held → pc=branch_target.
- Flush and wrap: flush=1 at pc=0x30 → pc=0x34, valid=0. Separately force pc=0xFFFF_FFFC via RESET_PC, step once → pc=0.
- IF_PERF_CNT_EN: 3 fetches, 1 stall, 2 redirects → fetch_cnt=3, bubble_cnt=2; reset mid-run clears both to 0.
